ram_param: RTL

Parametrised single-port synchronous RAM with per-byte write enables, an optional output register stage, a read-data valid strobe and a hardware clear sequencer. It zeroes the whole array after reset and on request. It is the general-purpose storage block for the datapath and supersedes the fixed 256 x 64 RAM. The `cen`/`wen`/`s_addr`/`s_din`/`s_dout` access interface is kept, so existing users port over directly.

---
 rtl/ram_param_if.sv | 26 ++
 rtl/ram_param.sv | 100 ++++++++++
 2 files changed

// File: rtl/ram_param_if.sv
// Access bus for ram_param: single-port word access with byte enables,
// read-valid strobe and the clear request/busy pair.
interface ram_param_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 8
);
    logic                  cen;
    logic                  wen;
    logic [DATA_W/8-1:0]   s_be;
    logic [ADDR_W-1:0]     s_addr;
    logic [DATA_W-1:0]     s_din;
    logic [DATA_W-1:0]     s_dout;
    logic                  s_valid;
    logic                  clr;
    logic                  busy;

    modport master (
        output cen, wen, s_be, s_addr, s_din, clr,
        input  s_dout, s_valid, busy
    );

    modport slave (
        input  cen, wen, s_be, s_addr, s_din, clr,
        output s_dout, s_valid, busy
    );
endinterface

// File: rtl/ram_param.sv
// Parametrised single-port RAM with byte enables, optional output register,
// read-valid strobe and a sequencer that zeroes the array after reset or on request.
module ram_param #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 2 ** ADDR_W,
    parameter int unsigned OUT_REG = 0
) (
    input logic        clk,
    input logic        rst,
    ram_param_if.slave bus
);
    localparam int unsigned       NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {StClear, StIdle} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                pipe_valid_q;
    logic [DATA_W-1:0]   pipe_data_q;

    logic                in_range;
    logic                acc;
    logic                rd_fire;
    logic                wr_fire;
    logic                sweep_we;
    logic [DATA_W-1:0]   rdata;

    // clr wins over any access presented in the same cycle
    always_comb begin
        in_range = ({1'b0, bus.s_addr} < DEPTH_W);
        acc      = (state_q == StIdle) && !bus.clr && bus.cen;
        rd_fire  = acc && !bus.wen;
        wr_fire  = acc && bus.wen && in_range;
        sweep_we = (state_q == StClear);
        rdata    = in_range ? mem[bus.s_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bus.s_be[i]) begin
                    mem[bus.s_addr][8*i +: 8] <= bus.s_din[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StClear;
            cnt_q        <= '0;
            bus.busy     <= 1'b1;
            bus.s_dout   <= '0;
            bus.s_valid  <= 1'b0;
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
        end else begin
            unique case (state_q)
                StClear: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST) begin
                        state_q  <= StIdle;
                        cnt_q    <= '0;
                        bus.busy <= 1'b0;
                    end
                end
                StIdle: begin
                    if (bus.clr) begin
                        state_q  <= StClear;
                        cnt_q    <= '0;
                        bus.busy <= 1'b1;
                    end
                end
            endcase

            // A read already in the output stage completes even if a clear starts
            if (OUT_REG != 0) begin
                pipe_valid_q <= rd_fire;
                if (rd_fire) begin
                    pipe_data_q <= rdata;
                end
                bus.s_valid <= pipe_valid_q;
                if (pipe_valid_q) begin
                    bus.s_dout <= pipe_data_q;
                end
            end else begin
                bus.s_valid <= rd_fire;
                if (rd_fire) begin
                    bus.s_dout <= rdata;
                end
            end
        end
    end
endmodule
